// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Predicts combinationally for the fetch PC and trains from resolved branches in ID.
module branch_predictor #(
  parameter int unsigned ENTRIES  = 16,
  parameter int unsigned XLEN     = 32,
  parameter int unsigned CNT_W    = 32,
  parameter logic [1:0]  CTR_INIT = 2'b01
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [XLEN-1:0]  if_pc,
  output logic             pred_taken,
  output logic [XLEN-1:0]  pred_target,
  input  logic             upd_valid,
  input  logic [XLEN-1:0]  upd_pc,
  input  logic             upd_is_jump,
  input  logic             upd_taken,
  input  logic [XLEN-1:0]  upd_target,
  input  logic             upd_pred_taken,
  input  logic [XLEN-1:0]  upd_pred_target,
  output logic             mispredict,
  output logic [CNT_W-1:0] mispredict_cnt
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = XLEN - IDX_W - 2;

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [XLEN-1:0]  target_q [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [IDX_W-1:0] lookupIdx, updIdx;
  logic [TAG_W-1:0] lookupTag, updTag;
  logic             lookupHit, updHit;
  logic             wrEn;
  logic [1:0]       ctr_d;
  logic [XLEN-1:0]  target_d;

  assign lookupIdx = if_pc[IDX_W+1:2];
  assign lookupTag = if_pc[XLEN-1:IDX_W+2];
  assign updIdx    = upd_pc[IDX_W+1:2];
  assign updTag    = upd_pc[XLEN-1:IDX_W+2];

  assign lookupHit   = valid_q[lookupIdx] && (tag_q[lookupIdx] == lookupTag);
  assign pred_taken  = lookupHit && ctr_q[lookupIdx][1];
  assign pred_target = pred_taken ? target_q[lookupIdx] : if_pc + XLEN'(4);

  assign updHit     = valid_q[updIdx] && (tag_q[updIdx] == updTag);
  assign mispredict = upd_valid &&
                      ((upd_pred_taken != upd_taken) ||
                       (upd_taken && (upd_pred_target != upd_target)));

  // Hits train in place; taken misses allocate over whatever aliases there.
  always_comb begin
    wrEn     = 1'b0;
    ctr_d    = ctr_q[updIdx];
    target_d = target_q[updIdx];
    if (upd_valid) begin
      if (updHit) begin
        wrEn = 1'b1;
        if (upd_is_jump)
          ctr_d = 2'b11;
        else if (upd_taken)
          ctr_d = (ctr_q[updIdx] == 2'b11) ? 2'b11 : 2'(ctr_q[updIdx] + 2'd1);
        else
          ctr_d = (ctr_q[updIdx] == 2'b00) ? 2'b00 : 2'(ctr_q[updIdx] - 2'd1);
        if (upd_taken)
          target_d = upd_target;
      end else if (upd_taken) begin
        wrEn     = 1'b1;
        ctr_d    = upd_is_jump ? 2'b11 : 2'b10;
        target_d = upd_target;
      end
    end
  end

  assign cnt_d = (mispredict && (cnt_q != {CNT_W{1'b1}})) ? cnt_q + CNT_W'(1) : cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= CTR_INIT;
      end
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (wrEn) begin
        valid_q[updIdx]  <= 1'b1;
        tag_q[updIdx]    <= updTag;
        target_q[updIdx] <= target_d;
        ctr_q[updIdx]    <= ctr_d;
      end
    end
  end

  assign mispredict_cnt = cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (16 entries), with a
// second CNT_W=2 instance sharing the stimulus to exercise counter saturation.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] if_pc;
  logic        pred_taken, pred_taken2;
  logic [31:0] pred_target, pred_target2;
  logic        upd_valid, upd_is_jump, upd_taken, upd_pred_taken;
  logic [31:0] upd_pc, upd_target, upd_pred_target;
  logic        mispredict, mispredict2;
  logic [31:0] mispredict_cnt;
  logic [1:0]  mispredict_cnt2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  branch_predictor #(.ENTRIES(16), .XLEN(32), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .if_pc(if_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_jump(upd_is_jump),
    .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .mispredict(mispredict), .mispredict_cnt(mispredict_cnt)
  );

  branch_predictor #(.ENTRIES(16), .XLEN(32), .CNT_W(2)) dutSat (
    .clk(clk), .reset(reset), .if_pc(if_pc),
    .pred_taken(pred_taken2), .pred_target(pred_target2),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_jump(upd_is_jump),
    .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .mispredict(mispredict2), .mispredict_cnt(mispredict_cnt2)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic lookup(input string tag, input logic [31:0] pc,
                        input logic expTaken, input logic [31:0] expTarget);
    if_pc = pc;
    #1;
    checkOutput({tag, ".taken"}, {31'd0, pred_taken}, {31'd0, expTaken});
    checkOutput({tag, ".target"}, pred_target, expTarget);
  endtask

  // Presents one resolved instruction for a single edge, checking mispredict first.
  task automatic applyStimulus(input string tag, input logic [31:0] pc,
                               input logic isJump, input logic taken,
                               input logic [31:0] target, input logic predTaken,
                               input logic [31:0] predTarget, input logic expMis);
    upd_valid       = 1'b1;
    upd_pc          = pc;
    upd_is_jump     = isJump;
    upd_taken       = taken;
    upd_target      = target;
    upd_pred_taken  = predTaken;
    upd_pred_target = predTarget;
    #1;
    checkOutput({tag, ".mispredict"}, {31'd0, mispredict}, {31'd0, expMis});
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; if_pc = 32'h0; upd_valid = 1'b0; upd_pc = 32'h0;
    upd_is_jump = 1'b0; upd_taken = 1'b0; upd_target = 32'h0;
    upd_pred_taken = 1'b0; upd_pred_target = 32'h0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    lookup("reset", 32'h40, 1'b0, 32'h44);
    checkOutput("reset.cnt", mispredict_cnt, 32'd0);
    lookup("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0);

    applyStimulus("alloc", 32'h100, 1'b0, 1'b1, 32'h80, 1'b0, 32'h104, 1'b1);
    checkOutput("alloc.cnt", mispredict_cnt, 32'd1);
    lookup("alloc", 32'h100, 1'b1, 32'h80);

    // Hysteresis: 10 -> 01 -> 00 -> 01
    applyStimulus("nt1", 32'h100, 1'b0, 1'b0, 32'h0, 1'b1, 32'h80, 1'b1);
    lookup("nt1", 32'h100, 1'b0, 32'h104);
    applyStimulus("nt2", 32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 32'h104, 1'b0);
    checkOutput("nt2.cnt", mispredict_cnt, 32'd2);
    applyStimulus("tk1", 32'h100, 1'b0, 1'b1, 32'h80, 1'b0, 32'h104, 1'b1);
    lookup("tk1", 32'h100, 1'b0, 32'h104);

    // Saturation: 01 -> 10 -> 11 -> 11 -> 11, then one not-taken -> 10
    applyStimulus("sat1", 32'h100, 1'b0, 1'b1, 32'h80, 1'b0, 32'h104, 1'b1);
    applyStimulus("sat2", 32'h100, 1'b0, 1'b1, 32'h80, 1'b1, 32'h80, 1'b0);
    applyStimulus("sat3", 32'h100, 1'b0, 1'b1, 32'h80, 1'b1, 32'h80, 1'b0);
    applyStimulus("sat4", 32'h100, 1'b0, 1'b1, 32'h80, 1'b1, 32'h80, 1'b0);
    checkOutput("sat.cnt", mispredict_cnt, 32'd4);
    applyStimulus("satNt", 32'h100, 1'b0, 1'b0, 32'h0, 1'b1, 32'h80, 1'b1);
    lookup("satNt", 32'h100, 1'b1, 32'h80);

    // Counter at 10: taken to a new target bumps to 11 and retargets
    applyStimulus("tgtMis", 32'h100, 1'b0, 1'b1, 32'h90, 1'b1, 32'h80, 1'b1);
    lookup("tgtMis", 32'h100, 1'b1, 32'h90);
    checkOutput("tgtMis.cnt", mispredict_cnt, 32'd6);

    lookup("alias.miss", 32'h140, 1'b0, 32'h144);
    if_pc = 32'h140;
    upd_valid = 1'b1; upd_pc = 32'h140; upd_is_jump = 1'b0; upd_taken = 1'b1;
    upd_target = 32'h200; upd_pred_taken = 1'b0; upd_pred_target = 32'h144;
    #1;
    checkOutput("bypass.taken", {31'd0, pred_taken}, 32'd0);
    checkOutput("alias.mispredict", {31'd0, mispredict}, 32'd1);
    @(posedge clk);
    #1 upd_valid = 1'b0;
    lookup("alias.new", 32'h140, 1'b1, 32'h200);
    lookup("alias.old", 32'h100, 1'b0, 32'h104);

    // Jump allocation must land at 11: one not-taken still predicts taken
    applyStimulus("jmp", 32'h208, 1'b1, 1'b1, 32'h300, 1'b0, 32'h20C, 1'b1);
    applyStimulus("jmpNt", 32'h208, 1'b0, 1'b0, 32'h0, 1'b1, 32'h300, 1'b1);
    lookup("jmpNt", 32'h208, 1'b1, 32'h300);

    applyStimulus("missNt", 32'h30C, 1'b0, 1'b0, 32'h0, 1'b0, 32'h310, 1'b0);
    lookup("missNt", 32'h30C, 1'b0, 32'h310);
    checkOutput("pre.cnt", mispredict_cnt, 32'd9);
    checkOutput("sat2.cnt", {30'd0, mispredict_cnt2}, 32'd3);

    // Reset coincident with an update: update is discarded
    reset = 1'b1;
    upd_valid = 1'b1; upd_pc = 32'h400; upd_is_jump = 1'b0; upd_taken = 1'b1;
    upd_target = 32'h500; upd_pred_taken = 1'b0; upd_pred_target = 32'h404;
    @(posedge clk);
    #1 reset = 1'b0; upd_valid = 1'b0;
    lookup("rst.new", 32'h400, 1'b0, 32'h404);
    lookup("rst.alias", 32'h140, 1'b0, 32'h144);
    lookup("rst.jmp", 32'h208, 1'b0, 32'h20C);
    checkOutput("rst.cnt", mispredict_cnt, 32'd0);
    checkOutput("rst.cnt2", {30'd0, mispredict_cnt2}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
